fir_axil_cfg_slave: RTL and testbench

AXI4-Lite responder (slave) register file for the FIR accelerator's control plane. It accepts 64-bit configuration writes and status reads from the host, and drives the static job configuration and coefficient-load strobes into the FIR datapath and DMA. It generates the start pulse and a level interrupt that the host clears by writing to the clear register. It sits between the host AXI-Lite interconnect and the FIR core/DMA engines.

---
 rtl/fir_cfg_pkg.sv | 37 +++
 rtl/fir_axil_cfg_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_fir_axil_cfg_slave.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_cfg_pkg.sv
`timescale 1ns/1ps
// fir_cfg_pkg: register map, CFG word layout, response codes and FSM state types
// shared by the FIR control-plane register file.
package fir_cfg_pkg;

    // Register indices, decoded from addr[6:3]
    localparam logic [3:0] REG_CTRL = 4'd0;
    localparam logic [3:0] REG_SRC  = 4'd1;
    localparam logic [3:0] REG_DST  = 4'd2;
    localparam logic [3:0] REG_CFG  = 4'd3;
    localparam logic [3:0] REG_COEF = 4'd4;
    localparam logic [3:0] REG_IRQ  = 4'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Static job configuration; occupies CFG word bits [28:0], auto_en at bit 0
    typedef struct packed {
        logic [3:0] out_rate;   // [28:25]
        logic [3:0] in_rate;    // [24:21]
        logic [7:0] delay;      // [20:13]
        logic [3:0] shift;      // [12:9]
        logic [7:0] tap;        // [8:1]
        logic       auto_en;    // [0]
    } fir_cfg_t;

    localparam int CFG_W = $bits(fir_cfg_t);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

    // CTRL read-back word: bit2 = interrupt pending, bit0 = busy
    function automatic logic [63:0] ctrl_status(input logic busy, input logic irq);
        return {61'b0, irq, 1'b0, busy};
    endfunction

endpackage

// File: rtl/fir_axil_cfg_slave.sv
`timescale 1ns/1ps
// fir_axil_cfg_slave: AXI4-Lite register file for the FIR accelerator control plane.
// Holds DMA source/destination, job config, coefficient push port, start/busy and
// the level interrupt. Read and write channels run independent FSMs.
module fir_axil_cfg_slave
    import fir_cfg_pkg::*;
#(
    parameter int AXIL_DATA_WIDTH = 64,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int NUM_REGISTER    = 6,
    parameter int MAX_TAPS        = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    // write address
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    // write data
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    // write response
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    // read address
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    // read data
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
    input  logic                         s_axil_rready,
    // job configuration
    output logic [31:0]                  src_addr,
    output logic [29:0]                  src_len,
    output logic [31:0]                  dst_addr,
    output logic [29:0]                  dst_len,
    output logic                         cfg_auto,
    output logic [7:0]                   cfg_tap,
    output logic [3:0]                   cfg_shift,
    output logic [7:0]                   cfg_delay,
    output logic [3:0]                   cfg_in_rate,
    output logic [3:0]                   cfg_out_rate,
    // coefficient load
    output logic                         coef_wr_en,
    output logic [7:0]                   coef_wr_idx,
    output logic [31:0]                  coef_wr_data,
    // job control
    output logic                         start,
    input  logic                         done,
    output logic                         busy,
    output logic                         interrupt_out
);

    localparam logic [7:0] MAX_IDX     = 8'(MAX_TAPS);
    localparam logic [3:0] NUM_REG_IDX = 4'(NUM_REGISTER);

    wr_state_e w_state, w_state_nxt;
    rd_state_e r_state, r_state_nxt;

    logic [3:0]                 wr_idx;
    logic [3:0]                 rd_idx;
    logic [1:0]                 bresp_q;
    logic [AXIL_DATA_WIDTH-1:0] rdata_q;
    logic [AXIL_DATA_WIDTH-1:0] rd_word;
    logic [AXIL_DATA_WIDTH-1:0] src_reg, dst_reg, cfg_reg;
    logic [7:0]                 coef_idx;
    logic                       aw_hs, w_hs, ar_hs;
    logic                       wr_err, wr_apply;
    logic                       start_req, irq_clr;
    fir_cfg_t                   cfg;

    // prot, strobes and address bits outside [6:3] carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb,
                           s_axil_awaddr[AXIL_ADDR_WIDTH-1:7], s_axil_awaddr[2:0],
                           s_axil_araddr[AXIL_ADDR_WIDTH-1:7], s_axil_araddr[2:0]};

    assign aw_hs  = s_axil_awvalid & s_axil_awready;
    assign w_hs   = s_axil_wvalid  & s_axil_wready;
    assign ar_hs  = s_axil_arvalid & s_axil_arready;
    assign rd_idx = s_axil_araddr[6:3];

    // ---------------- write channel ----------------

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    // Write FSM next state and channel handshake outputs; ready held low while in reset
    always_comb begin
        w_state_nxt    = w_state;
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axil_awready = ~rst;
                if (s_axil_awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s_axil_wready = 1'b1;
                if (s_axil_wvalid) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s_axil_bvalid = 1'b1;
                if (s_axil_bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign s_axil_bresp = bresp_q;

    // Decide whether the pending write is refused; refused writes have no side effect
    always_comb begin
        wr_err = 1'b0;
        case (wr_idx)
            REG_CTRL:                  wr_err = s_axil_wdata[1] & busy;
            REG_SRC, REG_DST, REG_CFG: wr_err = busy;
            REG_COEF:                  wr_err = busy | (coef_idx == MAX_IDX);
            default:                   wr_err = 1'b0;
        endcase
    end

    assign wr_apply  = w_hs & ~wr_err & (wr_idx < NUM_REG_IDX);
    assign start_req = wr_apply & (wr_idx == REG_CTRL) & s_axil_wdata[1];
    assign irq_clr   = wr_apply & (wr_idx == REG_IRQ);

    // Latch the register index on AW, then apply the data word on W
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx       <= '0;
            bresp_q      <= RESP_OKAY;
            src_reg      <= '0;
            dst_reg      <= '0;
            cfg_reg      <= '0;
            coef_idx     <= '0;
            coef_wr_en   <= 1'b0;
            coef_wr_idx  <= '0;
            coef_wr_data <= '0;
            start        <= 1'b0;
        end else begin
            start      <= start_req;
            coef_wr_en <= 1'b0;
            if (aw_hs) wr_idx <= s_axil_awaddr[6:3];
            if (w_hs)  bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
            if (wr_apply) begin
                case (wr_idx)
                    REG_CTRL: if (!s_axil_wdata[1]) coef_idx <= '0;
                    REG_SRC:  src_reg <= s_axil_wdata;
                    REG_DST:  dst_reg <= s_axil_wdata;
                    REG_CFG:  cfg_reg <= s_axil_wdata;
                    REG_COEF: begin
                        coef_wr_en   <= 1'b1;
                        coef_wr_idx  <= coef_idx;
                        coef_wr_data <= s_axil_wdata[31:0];
                        coef_idx     <= coef_idx + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Job status: a new start outranks done for busy, done outranks a clear for the irq
    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= 1'b0;
            interrupt_out <= 1'b0;
        end else begin
            if (start_req) busy <= 1'b1;
            else if (done) busy <= 1'b0;
            if (done)         interrupt_out <= 1'b1;
            else if (irq_clr) interrupt_out <= 1'b0;
        end
    end

    assign src_addr = src_reg[31:0];
    assign src_len  = src_reg[63:34];
    assign dst_addr = dst_reg[31:0];
    assign dst_len  = dst_reg[63:34];

    assign cfg          = fir_cfg_t'(cfg_reg[CFG_W-1:0]);
    assign cfg_auto     = cfg.auto_en;
    assign cfg_tap      = cfg.tap;
    assign cfg_shift    = cfg.shift;
    assign cfg_delay    = cfg.delay;
    assign cfg_in_rate  = cfg.in_rate;
    assign cfg_out_rate = cfg.out_rate;

    // ---------------- read channel ----------------

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    // Read FSM next state and channel handshake outputs
    always_comb begin
        r_state_nxt    = r_state;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axil_arready = ~rst;
                if (s_axil_arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                s_axil_rvalid = 1'b1;
                if (s_axil_rready) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read mux from current register state, so a same-cycle write is not visible
    always_comb begin
        rd_word = '0;
        case (rd_idx)
            REG_CTRL: rd_word = ctrl_status(busy, interrupt_out);
            REG_SRC:  rd_word = src_reg;
            REG_DST:  rd_word = dst_reg;
            REG_CFG:  rd_word = cfg_reg;
            REG_COEF: rd_word = {56'b0, coef_idx};
            default:  rd_word = '0;
        endcase
    end

    // Capture read data on the AR handshake; held until R completes
    always_ff @(posedge clk) begin
        if (rst)        rdata_q <= '0;
        else if (ar_hs) rdata_q <= rd_word;
    end

    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = RESP_OKAY;

endmodule

// File: tb/tb_fir_axil_cfg_slave.sv
`timescale 1ns/1ps
// tb_fir_axil_cfg_slave: directed AXI-Lite sequences against fir_axil_cfg_slave
// with hand-computed expectations checked by immediate assertions.
module tb_fir_axil_cfg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = 8'hFF;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] src_addr, dst_addr;
    logic [29:0] src_len, dst_len;
    logic        cfg_auto;
    logic [7:0]  cfg_tap, cfg_delay;
    logic [3:0]  cfg_shift, cfg_in_rate, cfg_out_rate;
    logic        coef_wr_en;
    logic [7:0]  coef_wr_idx;
    logic [31:0] coef_wr_data;
    logic        start;
    logic        done = 1'b0;
    logic        busy;
    logic        interrupt_out;

    int n_assert = 0;
    int n_fail   = 0;

    fir_axil_cfg_slave dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .src_addr(src_addr), .src_len(src_len), .dst_addr(dst_addr), .dst_len(dst_len),
        .cfg_auto(cfg_auto), .cfg_tap(cfg_tap), .cfg_shift(cfg_shift), .cfg_delay(cfg_delay),
        .cfg_in_rate(cfg_in_rate), .cfg_out_rate(cfg_out_rate),
        .coef_wr_en(coef_wr_en), .coef_wr_idx(coef_wr_idx), .coef_wr_data(coef_wr_data),
        .start(start), .done(done), .busy(busy), .interrupt_out(interrupt_out)
    );

    always #5 clk = ~clk;

    // Strobe monitor: log every coefficient write and count start-high cycles
    int          coef_cnt  = 0;
    int          start_cnt = 0;
    logic [7:0]  idx_log [0:511];
    logic [31:0] dat_log [0:511];
    always @(negedge clk) begin
        if (coef_wr_en && coef_cnt < 512) begin
            idx_log[coef_cnt] = coef_wr_idx;
            dat_log[coef_cnt] = coef_wr_data;
            coef_cnt++;
        end
        if (start) start_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axil_write(input logic [31:0] addr, input logic [63:0] data, input int bdly,
                              input logic dn, output logic [1:0] resp, output int cyc);
        logic       hs;
        logic [1:0] held;
        resp = 2'bxx; held = 2'b00; cyc = 0;
        awaddr = addr; awvalid = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = awready; @(posedge clk); #1; cyc++;
        end
        awvalid = 1'b0;
        chk("aw_handshake", hs, 1);
        wdata = data; wvalid = 1'b1; done = dn; hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = wready; @(posedge clk); #1; cyc++;
        end
        wvalid = 1'b0; done = 1'b0;
        chk("w_handshake", hs, 1);
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid, 1);
            chk("awready_low", awready, 0);
            if (i == 0) held = bresp;
            @(posedge clk); #1; cyc++;
        end
        bready = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = bvalid; resp = bresp; @(posedge clk); #1; cyc++;
        end
        bready = 1'b0;
        chk("b_handshake", hs, 1);
        if (bdly > 0) chk("bresp_stable", resp, held);
    endtask

    task automatic axil_read(input logic [31:0] addr, input int rdly,
                             output logic [63:0] data, output logic [1:0] resp, output int cyc);
        logic        hs;
        logic [63:0] held;
        data = '0; resp = 2'bxx; held = '0; cyc = 0;
        araddr = addr; arvalid = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = arready; @(posedge clk); #1; cyc++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", hs, 1);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid, 1);
            chk("arready_low", arready, 0);
            if (i == 0) held = rdata;
            @(posedge clk); #1; cyc++;
        end
        rready = 1'b1; hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk); hs = rvalid; data = rdata; resp = rresp; @(posedge clk); #1; cyc++;
        end
        rready = 1'b0;
        chk("r_handshake", hs, 1);
        if (rdly > 0) chk("rdata_stable", data, held);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [63:0] rd, w1, w2, w3, coef_w;
        logic [15:0] hi, lo;
        int          cyc, c0, s0, n_ok;

        // ---- reset ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", awready, 1);
        chk("post_rst_arready", arready, 1);
        chk("post_rst_wready", wready, 0);
        chk("post_rst_start", start, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_irq", interrupt_out, 0);
        chk("post_rst_coef_en", coef_wr_en, 0);
        chk("post_rst_src", {src_len, src_addr}, 0);
        chk("post_rst_cfg", {cfg_out_rate, cfg_in_rate, cfg_delay, cfg_shift, cfg_tap, cfg_auto}, 0);
        @(posedge clk); #1;

        // ---- SRC / DST ----
        w1 = {30'd23, 2'b0, 32'd46};
        w2 = {30'd100, 2'b0, 32'd52};
        axil_write(32'h08, w1, 0, 1'b0, resp, cyc);
        chk("src_bresp", resp, 2'b00);
        chk("src_cycles_ge3", cyc >= 3, 1);
        axil_write(32'h10, w2, 5, 1'b0, resp, cyc);
        chk("dst_bresp", resp, 2'b00);
        chk("src_len", src_len, 23);
        chk("src_addr", src_addr, 46);
        chk("dst_len", dst_len, 100);
        chk("dst_addr", dst_addr, 52);

        // ---- CFG ----
        w3 = {35'b0, 4'd0, 4'd0, 8'd3, 4'd2, 8'd7, 1'b1};
        axil_write(32'h18, w3, 0, 1'b0, resp, cyc);
        chk("cfg_bresp", resp, 2'b00);
        chk("cfg_delay", cfg_delay, 3);
        chk("cfg_shift", cfg_shift, 2);
        chk("cfg_tap", cfg_tap, 7);
        chk("cfg_auto", cfg_auto, 1);
        chk("cfg_rates", {cfg_out_rate, cfg_in_rate}, 0);
        axil_read(32'h18, 5, rd, resp, cyc);
        chk("cfg_readback", rd, 64'h640F);
        chk("cfg_rresp", resp, 2'b00);
        axil_read(32'h08, 0, rd, resp, cyc);
        chk("src_readback", rd, w1);
        chk("read_cycles", cyc, 2);

        // ---- coefficient push ----
        axil_write(32'h00, 64'd0, 0, 1'b0, resp, cyc);
        c0 = coef_cnt;
        for (int j = 0; j < 17; j++) begin
            hi = 16'(17 - j); lo = 16'(14 - j);
            coef_w = {32'd0, hi, lo};
            axil_write(32'h20, coef_w, 0, 1'b0, resp, cyc);
            chk("coef_bresp", resp, 2'b00);
        end
        @(negedge clk);
        chk("coef_pulses", coef_cnt - c0, 17);
        chk("coef_idx_first", idx_log[c0], 0);
        chk("coef_idx_last", idx_log[c0 + 16], 16);
        chk("coef_data_first", dat_log[c0], 32'h0011_000E);
        chk("coef_data_last", dat_log[c0 + 16], 32'h0001_FFFE);
        @(posedge clk); #1;
        axil_read(32'h20, 0, rd, resp, cyc);
        chk("coef_index_read", rd, 17);

        // ---- start / busy ----
        s0 = start_cnt;
        axil_write(32'h00, 64'd2, 0, 1'b0, resp, cyc);
        chk("start_bresp", resp, 2'b00);
        chk("start_pulse_cycles", start_cnt - s0, 1);
        chk("busy_set", busy, 1);
        axil_read(32'h00, 0, rd, resp, cyc);
        chk("ctrl_read_busy", rd, 64'd1);
        axil_write(32'h08, {30'd9, 2'b0, 32'd9}, 0, 1'b0, resp, cyc);
        chk("src_busy_slverr", resp, 2'b10);
        chk("src_unchanged", {src_len, src_addr}, {30'd23, 32'd46});
        axil_write(32'h00, 64'd2, 0, 1'b0, resp, cyc);
        chk("restart_slverr", resp, 2'b10);
        chk("restart_no_pulse", start_cnt - s0, 1);
        c0 = coef_cnt;
        axil_write(32'h20, 64'h1234, 0, 1'b0, resp, cyc);
        chk("coef_busy_slverr", resp, 2'b10);
        chk("coef_busy_no_strobe", coef_cnt - c0, 0);

        // ---- completion and interrupt ----
        done = 1'b1; @(posedge clk); #1; done = 1'b0;
        @(negedge clk);
        chk("done_busy_clr", busy, 0);
        chk("done_irq_set", interrupt_out, 1);
        @(posedge clk); #1;
        axil_read(32'h00, 0, rd, resp, cyc);
        chk("ctrl_read_irq", rd, 64'd4);
        axil_write(32'h28, 64'd0, 0, 1'b0, resp, cyc);
        chk("irq_clr_bresp", resp, 2'b00);
        chk("irq_cleared", interrupt_out, 0);
        axil_write(32'h28, 64'd0, 0, 1'b1, resp, cyc);
        chk("irq_set_wins", interrupt_out, 1);
        chk("idle_done_busy", busy, 0);
        axil_write(32'h28, 64'd0, 0, 1'b0, resp, cyc);
        chk("irq_cleared_again", interrupt_out, 0);

        // ---- unmapped and aliased addresses ----
        axil_write(32'h38, 64'hDEAD_BEEF, 0, 1'b0, resp, cyc);
        chk("unmapped_bresp", resp, 2'b00);
        axil_read(32'h38, 0, rd, resp, cyc);
        chk("unmapped_read", rd, 0);
        chk("unmapped_rresp", resp, 2'b00);
        axil_read(32'h1000_000C, 0, rd, resp, cyc);
        chk("alias_read_src", rd, w1);

        // ---- coefficient table full ----
        axil_write(32'h00, 64'd0, 0, 1'b0, resp, cyc);
        c0 = coef_cnt; n_ok = 0;
        for (int j = 0; j < 255; j++) begin
            axil_write(32'h20, 64'(j), 0, 1'b0, resp, cyc);
            if (resp == 2'b00) n_ok++;
        end
        chk("coef_full_okays", n_ok, 255);
        chk("coef_full_pulses", coef_cnt - c0, 255);
        chk("coef_full_last_idx", idx_log[c0 + 254], 254);
        axil_read(32'h20, 0, rd, resp, cyc);
        chk("coef_full_index", rd, 255);
        c0 = coef_cnt;
        axil_write(32'h20, 64'd7, 0, 1'b0, resp, cyc);
        chk("coef_overflow_slverr", resp, 2'b10);
        chk("coef_overflow_no_strobe", coef_cnt - c0, 0);

        // ---- reset in the middle of transactions ----
        awaddr = 32'h08; awvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        chk("mid_rvalid_before_rst", rvalid, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_bvalid", bvalid, 0);
        chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_awready", awready, 1);
        chk("mid_rst_arready", arready, 1);
        chk("mid_rst_src", src_addr, 0);
        @(posedge clk); #1;
        axil_write(32'h10, w2, 0, 1'b0, resp, cyc);
        chk("post_mid_rst_write", {dst_len, dst_addr}, {30'd100, 32'd52});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
